// File: rtl/updown_sweep_ctrl.sv
// Sequencer for a 5-bit up/down counter.
// Ping-pongs the counter between latched bounds lo and hi for a programmed number of sweeps.
module updown_sweep_ctrl #(
   parameter int unsigned W  = 5,
   parameter int unsigned NW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          stop,
   input  logic [W-1:0]  lo,
   input  logic [W-1:0]  hi,
   input  logic [NW-1:0] num_sweeps,
   input  logic [W-1:0]  count_in,
   output logic          up_down,
   output logic          cnt_rst,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [NW-1:0] sweeps_done
);

   localparam int unsigned WE = W + 1;

   typedef enum logic [1:0] {IDLE, UP, DOWN, FIN} state_t;

   state_t        state;
   logic [W-1:0]  lo_q;
   logic [W-1:0]  hi_q;
   logic [NW-1:0] ns_q;

   logic [WE-1:0] hi_ext_c;
   logic [WE-1:0] lo_min_c;
   logic          cfg_ok_c;
   logic          at_peak_c;
   logic          at_floor_c;
   logic [NW-1:0] sweeps_inc_c;

   // Bound check widened by one bit so lo+2 cannot wrap.
   assign hi_ext_c     = {1'b0, hi};
   assign lo_min_c     = {1'b0, lo} + WE'(2);
   assign cfg_ok_c     = (hi_ext_c >= lo_min_c);
   assign at_peak_c    = (count_in == (hi_q - W'(1)));
   assign at_floor_c   = (count_in == (lo_q + W'(1)));
   assign sweeps_inc_c = sweeps_done + NW'(1);

   // Turn decisions are one count early because the counter steps on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         lo_q        <= '0;
         hi_q        <= '0;
         ns_q        <= '0;
         up_down     <= 1'b0;
         cnt_rst     <= 1'b1;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         sweeps_done <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (cfg_ok_c) begin
                     lo_q        <= lo;
                     hi_q        <= hi;
                     ns_q        <= num_sweeps;
                     sweeps_done <= '0;
                     cnt_rst     <= 1'b0;
                     up_down     <= 1'b1;
                     busy        <= 1'b1;
                     state       <= UP;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            UP: begin
               if (stop) begin
                  cnt_rst <= 1'b1;
                  up_down <= 1'b0;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end else if (at_peak_c) begin
                  up_down <= 1'b0;
                  state   <= DOWN;
               end
            end
            DOWN: begin
               if (stop) begin
                  cnt_rst <= 1'b1;
                  up_down <= 1'b0;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end else if (at_floor_c) begin
                  sweeps_done <= sweeps_inc_c;
                  if ((ns_q != '0) && (sweeps_inc_c == ns_q)) begin
                     state <= FIN;
                  end else begin
                     up_down <= 1'b1;
                     state   <= UP;
                  end
               end
            end
            FIN: begin
               cnt_rst <= 1'b1;
               up_down <= 1'b0;
               busy    <= 1'b0;
               done    <= !stop;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Scoreboard bench for updown_sweep_ctrl driving a behavioural 5-bit up/down counter.
module tb_updown_sweep_ctrl;

   localparam int unsigned W  = 5;
   localparam int unsigned NW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          stop;
   logic [W-1:0]  lo;
   logic [W-1:0]  hi;
   logic [NW-1:0] num_sweeps;
   logic [W-1:0]  count;
   logic          up_down;
   logic          cnt_rst;
   logic          busy;
   logic          done;
   logic          err;
   logic [NW-1:0] sweeps_done;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Cycle record: {count, up_down, cnt_rst, busy, done, err, sweeps_done}
   typedef struct {
      int          at;
      string       name;
      logic [13:0] v;
   } exp_t;

   // Event record: {done, err, sweeps_done}
   typedef struct {
      string       name;
      logic [5:0]  v;
   } ev_t;

   exp_t cq[$];
   ev_t  eq[$];

   updown_sweep_ctrl #(.W(W), .NW(NW)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .stop        (stop),
      .lo          (lo),
      .hi          (hi),
      .num_sweeps  (num_sweeps),
      .count_in    (count),
      .up_down     (up_down),
      .cnt_rst     (cnt_rst),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .sweeps_done (sweeps_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Counter datapath being sequenced.
   always @(posedge clk or posedge cnt_rst) begin
      if (cnt_rst) count <= '0;
      else         count <= up_down ? count + 5'd1 : count - 5'd1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic push(input string nm, input int at, input int c, input int ud, input int crst,
                       input int bsy, input int dn, input int er, input int sd);
      exp_t e;
      e.at   = at;
      e.name = nm;
      e.v    = {5'(c), 1'(ud), 1'(crst), 1'(bsy), 1'(dn), 1'(er), 4'(sd)};
      cq.push_back(e);
   endtask

   task automatic push_ev(input string nm, input int dn, input int er, input int sd);
      ev_t e;
      e.name = nm;
      e.v    = {1'(dn), 1'(er), 4'(sd)};
      eq.push_back(e);
   endtask

   // lo=2, hi=6, one sweep; entry k is the state after edge T(t0+k).
   task automatic push_single(input string nm, input int t0, input int n);
      int c[12]  = '{0,1,2,3,4,5,6,5,4,3,2,0};
      int ud[12] = '{1,1,1,1,1,1,0,0,0,0,0,0};
      int sd[12] = '{0,0,0,0,0,0,0,0,0,0,1,1};
      for (int k = 0; k < n; k++) begin
         push($sformatf("%s_k%0d", nm, k), t0 + k, c[k], ud[k],
              (k == 11) ? 1 : 0, (k == 11) ? 0 : 1, (k == 11) ? 1 : 0, 0, sd[k]);
      end
   endtask

   // lo=2, hi=6, two sweeps.
   task automatic push_two(input string nm, input int t0, input int n);
      int c[20]  = '{0,1,2,3,4,5,6,5,4,3,2,3,4,5,6,5,4,3,2,0};
      int ud[20] = '{1,1,1,1,1,1,0,0,0,0,1,1,1,1,0,0,0,0,0,0};
      int sd[20] = '{0,0,0,0,0,0,0,0,0,0,1,1,1,1,1,1,1,1,2,2};
      for (int k = 0; k < n; k++) begin
         push($sformatf("%s_k%0d", nm, k), t0 + k, c[k], ud[k],
              (k == 19) ? 1 : 0, (k == 19) ? 0 : 1, (k == 19) ? 1 : 0, 0, sd[k]);
      end
   endtask

   // Monitor: cycle records fall due on their cycle; done/err pulses pop the event queue.
   always @(negedge clk) begin
      exp_t e;
      ev_t  v;
      while (cq.size() > 0 && cq[0].at <= cyc) begin
         e = cq.pop_front();
         if (e.at == cyc) begin
            chk(e.name, 32'({count, up_down, cnt_rst, busy, done, err, sweeps_done}), 32'(e.v));
         end else begin
            checks++;
            errors++;
            $display("FAIL %s missed at cycle %0d required=%0h", e.name, e.at, e.v);
         end
      end
      if (done || err) begin
         if (eq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse cycle=%0d done=%0b err=%0b required none", cyc, done, err);
         end else begin
            v = eq.pop_front();
            chk(v.name, 32'({done, err, sweeps_done}), 32'(v.v));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input int a_lo, input int a_hi, input int a_ns, input logic a_stop,
                         output int t0);
      lo         = W'(a_lo);
      hi         = W'(a_hi);
      num_sweeps = NW'(a_ns);
      start      = 1'b1;
      stop       = a_stop;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      t0    = cyc;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      reset      = 1'b1;
      start      = 1'b0;
      stop       = 1'b0;
      lo         = '0;
      hi         = '0;
      num_sweeps = '0;
      tick();
      tick();
      chk("rst_up_down", 32'(up_down), 32'd0);
      chk("rst_cnt_rst", 32'(cnt_rst), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done_err", 32'({done, err}), 32'd0);
      chk("rst_sweeps_done", 32'(sweeps_done), 32'd0);
      reset = 1'b0;
      tick();

      // Single sweep
      launch(2, 6, 1, 1'b0, t0);
      push_single("single", t0, 12);
      push_ev("single_done", 1, 0, 1);
      repeat (13) tick();

      // Two sweeps
      launch(2, 6, 2, 1'b0, t0);
      push_two("two", t0, 20);
      push_ev("two_done", 1, 0, 2);
      repeat (21) tick();

      // Invalid config (hi = lo+1): err only, sweeps_done from last run holds
      launch(5, 6, 1, 1'b0, t0);
      push("invalid_k0", t0, 0, 0, 1, 0, 0, 1, 2);
      push("invalid_k1", t0 + 1, 0, 0, 1, 0, 0, 0, 2);
      push_ev("invalid_err", 0, 1, 2);
      repeat (3) tick();

      // Continuous full range, start+stop together in IDLE, then stop mid-descent
      launch(0, 31, 0, 1'b1, t0);
      push("cont_k0",   t0,       0, 1, 0, 1, 0, 0, 0);
      push("cont_k30",  t0 + 30, 30, 1, 0, 1, 0, 0, 0);
      push("cont_k31",  t0 + 31, 31, 0, 0, 1, 0, 0, 0);
      push("cont_k32",  t0 + 32, 30, 0, 0, 1, 0, 0, 0);
      push("cont_k62",  t0 + 62,  0, 1, 0, 1, 0, 0, 1);
      push("cont_k63",  t0 + 63,  1, 1, 0, 1, 0, 0, 1);
      push("cont_k93",  t0 + 93, 31, 0, 0, 1, 0, 0, 1);
      push("cont_k99",  t0 + 99, 25, 0, 0, 1, 0, 0, 1);
      push("cont_k100", t0 + 100, 0, 0, 1, 0, 0, 0, 1);
      push("cont_k101", t0 + 101, 0, 0, 1, 0, 0, 0, 1);
      repeat (99) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      repeat (3) tick();

      // Reset during second ascent with count 4
      launch(2, 6, 2, 1'b0, t0);
      push_two("prerst", t0, 13);
      repeat (12) tick();
      @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("midrst_up_down", 32'(up_down), 32'd0);
      chk("midrst_cnt_rst", 32'(cnt_rst), 32'd1);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_sweeps_done", 32'(sweeps_done), 32'd0);
      chk("midrst_count", 32'(count), 32'd0);
      tick();
      reset = 1'b0;
      tick();
      launch(2, 6, 1, 1'b0, t0);
      push_single("postrst", t0, 12);
      push_ev("postrst_done", 1, 0, 1);
      repeat (13) tick();

      // Inputs changed while busy and start during DOWN are ignored
      launch(2, 6, 1, 1'b0, t0);
      push_single("cfgchg", t0, 12);
      push_ev("cfgchg_done", 1, 0, 1);
      repeat (2) tick();
      hi         = 5'd10;
      lo         = 5'd0;
      num_sweeps = 4'd3;
      repeat (5) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (6) tick();

      chk("cycle_queue_drained", 32'(cq.size()), 32'd0);
      chk("event_queue_drained", 32'(eq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/updown_sweep_ctrl.md
Name: updown_sweep_ctrl

Overview:
- Sequencer for the 5-bit up/down counter datapath. The counter steps every clock: up_down=1 counts up, up_down=0 counts down, and an active-high reset clears it to 0.
- The block drives the counter's direction and reset. It watches the counter value so the counter ping-pongs between programmable bounds lo and hi for a programmed number of sweeps.
- When idle or finished, it holds the counter at 0.

Parameters:
- W, 5, counter / bound width.
- NW, 4, width of the sweep count and sweep counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high block reset.
- start  input  1  single-cycle request to begin a sweep sequence. Sampled in IDLE only.
- stop  input  1  abort. Sampled in any busy state.
- lo  input  W  lower turn-around bound.
- hi  input  W  upper turn-around bound.
- num_sweeps  input  NW  number of full sweeps; 0 = continuous until stop.
- count_in  input  W  current counter value (counter's count output).
- up_down  output  1  registered direction to counter; 1 = up.
- cnt_rst  output  1  registered reset to the counter's reset input.
- busy  output  1  high while in UP, DOWN or FIN.
- done  output  1  one-cycle pulse when the final sweep completes.
- err  output  1  one-cycle pulse on start with an invalid configuration.
- sweeps_done  output  NW  completed sweeps in the current or last run.

Behaviour:
- Reset values: up_down=0, cnt_rst=1, busy=0, done=0, err=0, sweeps_done=0, state=IDLE. Reset asserted mid-operation aborts immediately to these values.
- States: IDLE, UP, DOWN, FIN. All outputs are registered.
- IDLE: cnt_rst=1, so the counter stays at 0.
- start in IDLE, config valid (hi >= lo+2):
  - Latch lo, hi, num_sweeps.
  - Clear sweeps_done.
  - On that edge (T0): cnt_rst<=0, up_down<=1, state<=UP.
  - Counter reads 0 after T0, then increments each edge.
- start in IDLE, config invalid: err pulses one cycle, state stays IDLE, latched config unchanged.
- UP: on the edge where count_in==hi-1, set up_down<=0 and go to DOWN. The counter peaks at hi for exactly one cycle.
- DOWN, on the edge where count_in==lo+1 (counter reaches lo on this edge):
  - sweeps_done increments, wrapping at 2^NW.
  - If num_sweeps!=0 and the incremented value equals num_sweeps: go to FIN, up_down stays 0.
  - Otherwise: up_down<=1 and go to UP, so the counter turns at lo.
- FIN: lasts one cycle with count_in==lo. On the next edge: state<=IDLE, cnt_rst<=1, done<=1 (one cycle), busy<=0. The counter's async reset then settles it to 0.
- Cycle counts:
  - First ascent (0 to hi): hi cycles.
  - Each later ascent and each descent: hi-lo cycles.
- Latched lo/hi/num_sweeps are used throughout the run. Input changes while busy are ignored.
- start while busy is ignored.
- stop while busy: next edge goes to IDLE with cnt_rst<=1, busy<=0, no done pulse; sweeps_done holds. stop has priority over the turn and FIN transitions. stop in IDLE has no effect.
- start and stop together in IDLE: start is taken; stop is ignored because it is not sampled in IDLE.
- lo=0 is legal. hi=31 is legal (turn at count_in==30, no wrap).
- num_sweeps=0: sweeps_done wraps freely and done never pulses.

Test Plan:
- Single sweep: lo=2, hi=6, num_sweeps=1, start at T0.
  - count after T1..T6 = 1..6; after T7..T10 = 5,4,3,2.
  - FIN after T10; done=1 and cnt_rst=1 after T11, count 0.
  - sweeps_done=1, busy high T0..T11.
- Two sweeps, same bounds, num_sweeps=2:
  - turn-up at lo after T10 (count 3 after T11), peak 6 after T14, 2 after T18.
  - done after T19, sweeps_done=2.
- Invalid config: lo=5, hi=6, start.
  - err pulses one cycle; busy=0, cnt_rst stays 1, count stays 0.
- Continuous with stop: lo=0, hi=31, num_sweeps=0.
  - Verify peak 31 with no wrap, and turn at 0.
  - Assert stop mid-descent: next edge cnt_rst=1, count 0, no done, sweeps_done holds.
- Reset mid-run: assert reset during UP with count=4.
  - Immediately up_down=0, cnt_rst=1, busy=0, sweeps_done=0.
  - After release, a fresh start runs normally.
- Config change while busy: change hi from 6 to 10 during UP (lo=2, hi=6, num_sweeps=1).
  - Peak is still 6.
  - start pulse during DOWN is ignored.
